// File: rtl/fsk_demodulator.sv
// FSK receiver: measures half-periods of the incoming square wave, classifies them as
// mark/space, locks onto the carrier and recovers the bit with a confirmation count.
module fsk_demodulator #(
  parameter int unsigned HIGH_HALF   = 25,
  parameter int unsigned LOW_HALF    = 50,
  parameter int unsigned THRESH      = 37,
  parameter int unsigned GLITCH_MIN  = 8,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned LOCK_HALVES = 4,
  parameter int unsigned CONFIRM     = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic signal_in,
  output logic bit_out,
  output logic carrier_det,
  output logic sym_strobe,
  output logic glitch_err
);

  localparam int unsigned AcqW = $clog2(LOCK_HALVES + 1);
  localparam int unsigned RunW = $clog2(CONFIRM + 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] GlitchMinC = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] ThreshC    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] TimeoutC   = CNT_W'(TIMEOUT);
  localparam logic [AcqW-1:0]  AcqLast    = AcqW'(LOCK_HALVES - 1);
  localparam logic [RunW-1:0]  RunLast    = RunW'(CONFIRM - 1);

  if ((HIGH_HALF > THRESH) || (LOW_HALF <= THRESH) || (GLITCH_MIN > THRESH) ||
      (TIMEOUT > (2 ** CNT_W) - 1)) begin : g_bad_cfg
    $error("fsk_demodulator: inconsistent timing parameters");
  end

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [AcqW-1:0]  acq_q, acq_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             bit_q, bit_d;
  logic             cd_q, cd_d;
  logic             sym_q, sym_d;
  logic             glitch_q, glitch_d;

  logic sig_edge, is_glitch, is_valid, cls, timeout;

  // cnt_q holds the length of the half that just ended whenever sig_edge is high.
  always_comb begin
    sig_edge  = s2_q ^ s3_q;
    is_glitch = sig_edge && (cnt_q < GlitchMinC);
    is_valid  = sig_edge && !is_glitch;
    cls       = (cnt_q <= ThreshC);
    timeout   = !sig_edge && (cnt_q >= TimeoutC);
  end

  always_comb begin
    if (sig_edge) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    acq_d    = acq_q;
    run_d    = run_q;
    bit_d    = bit_q;
    cd_d     = cd_q;
    sym_d    = 1'b0;
    glitch_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The first half after idle has no known start, so it is dropped.
        if (sig_edge) begin
          state_d = StAcquire;
          acq_d   = '0;
        end
      end
      StAcquire: begin
        if (is_glitch) begin
          acq_d    = '0;
          glitch_d = 1'b1;
        end else if (is_valid) begin
          if (acq_q == AcqLast) begin
            state_d = StLocked;
            bit_d   = cls;
            cd_d    = 1'b1;
            run_d   = '0;
          end else begin
            acq_d = acq_q + AcqW'(1);
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StLocked: begin
        if (is_valid) begin
          sym_d = 1'b1;
          if (cls == bit_q) begin
            run_d = '0;
          end else if (run_q == RunLast) begin
            bit_d = cls;
            run_d = '0;
          end else begin
            run_d = run_q + RunW'(1);
          end
        end else if (is_glitch) begin
          glitch_d = 1'b1;
          run_d    = '0;
        end else if (timeout) begin
          state_d = StIdle;
          cd_d    = 1'b0;
          bit_d   = 1'b1;
          run_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s3_q     <= 1'b1;
      cnt_q    <= '0;
      state_q  <= StIdle;
      acq_q    <= '0;
      run_q    <= '0;
      bit_q    <= 1'b1;
      cd_q     <= 1'b0;
      sym_q    <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      s1_q     <= signal_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      acq_q    <= acq_d;
      run_q    <= run_d;
      bit_q    <= bit_d;
      cd_q     <= cd_d;
      sym_q    <= sym_d;
      glitch_q <= glitch_d;
    end
  end

  assign bit_out     = bit_q;
  assign carrier_det = cd_q;
  assign sym_strobe  = sym_q;
  assign glitch_err  = glitch_q;

endmodule

// File: tb/tb_fsk_demodulator.sv
// Bench for fsk_demodulator: table of waveform segments with end-of-segment expectations,
// hand sequences for timeout/reset, then random halves checked cycle by cycle against a model.
module tb_fsk_demodulator;

  localparam int THRESH      = 37;
  localparam int GLITCH_MIN  = 8;
  localparam int TIMEOUT     = 200;
  localparam int LOCK_HALVES = 4;
  localparam int CONFIRM     = 2;
  localparam int CNT_MAX     = 255;

  localparam int KSeg     = 0;
  localparam int KHold    = 1;
  localparam int KTimeout = 2;
  localparam int KReset   = 3;

  localparam int PIdle = 0;
  localparam int PAcq  = 1;
  localparam int PLock = 2;

  typedef struct {
    int   kind;
    int   half;
    int   n;
    logic exp_bit;
    logic exp_cd;
    int   exp_sym;
    int   exp_gl;
  } vec_t;

  logic sysclk = 1'b0;
  logic rst_n;
  logic signal_in;
  logic bit_out, carrier_det, sym_strobe, glitch_err;

  fsk_demodulator dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .signal_in   (signal_in),
    .bit_out     (bit_out),
    .carrier_det (carrier_det),
    .sym_strobe  (sym_strobe),
    .glitch_err  (glitch_err)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;
  int sym_cnt  = 0;
  int gl_cnt   = 0;
  logic lvl    = 1'b1;

  // Reference model: time-since-last-edge arithmetic and plain counters.
  logic hist[$];
  int   cyc = 0;
  int   last_edge = 0;
  int   phase = PIdle;
  int   good = 0;
  int   streak = 0;
  logic m_bit = 1'b1, m_cd = 1'b0, m_sym = 1'b0, m_gl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic sig, input logic rst);
    int   elapsed;
    logic edge_now, cls;
    if (!rst) begin
      hist = '{1'b1, 1'b1, 1'b1};
      last_edge = cyc + 1;
      phase = PIdle; good = 0; streak = 0;
      m_bit = 1'b1; m_cd = 1'b0; m_sym = 1'b0; m_gl = 1'b0;
    end else begin
      edge_now = (hist[1] != hist[2]);
      elapsed = cyc - last_edge;
      if (elapsed > CNT_MAX) elapsed = CNT_MAX;
      m_sym = 1'b0;
      m_gl = 1'b0;
      if (edge_now) begin
        last_edge = cyc;
        if (phase == PIdle) begin
          phase = PAcq;
          good = 0;
        end else if (elapsed < GLITCH_MIN) begin
          m_gl = 1'b1;
          if (phase == PAcq) good = 0;
          else streak = 0;
        end else begin
          cls = (elapsed <= THRESH);
          if (phase == PAcq) begin
            good++;
            if (good == LOCK_HALVES) begin
              phase = PLock; m_bit = cls; m_cd = 1'b1; streak = 0;
            end
          end else begin
            m_sym = 1'b1;
            if (cls == m_bit) streak = 0;
            else begin
              streak++;
              if (streak == CONFIRM) begin
                m_bit = cls;
                streak = 0;
              end
            end
          end
        end
      end else if (elapsed >= TIMEOUT && phase != PIdle) begin
        if (phase == PLock) begin
          m_bit = 1'b1;
          m_cd = 1'b0;
        end
        phase = PIdle;
      end
      hist.push_front(sig);
      void'(hist.pop_back());
    end
    cyc++;
  endtask

  task automatic tick(input logic sig, input logic rst);
    signal_in = sig;
    rst_n = rst;
    @(posedge sysclk);
    model_step(sig, rst);
    #1;
    check("cycle_outputs", {28'd0, bit_out, carrier_det, sym_strobe, glitch_err},
          {28'd0, m_bit, m_cd, m_sym, m_gl});
    if (sym_strobe === 1'b1) sym_cnt++;
    if (glitch_err === 1'b1) gl_cnt++;
  endtask

  task automatic run_seg(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      lvl = ~lvl;
      for (int k = 0; k < half; k++) tick(lvl, 1'b1);
    end
  endtask

  // Last edge sampled at tick 0; loss must appear exactly TIMEOUT+2 ticks later.
  task automatic do_timeout();
    lvl = ~lvl;
    tick(lvl, 1'b1);
    for (int k = 0; k < TIMEOUT + 1; k++) tick(lvl, 1'b1);
    check("timeout_not_early", {30'd0, carrier_det, bit_out}, {30'd0, 1'b1, 1'b0});
    tick(lvl, 1'b1);
    check("timeout_cd_drop", {31'd0, carrier_det}, 32'd0);
    check("timeout_bit_idle", {31'd0, bit_out}, 32'd1);
    for (int k = 0; k < 20; k++) tick(lvl, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
    lvl = 1'b1;
    check("reset_midlock", {28'd0, bit_out, carrier_det, sym_strobe, glitch_err},
          {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  function automatic vec_t mk(input int kind, input int half, input int n, input logic b,
                              input logic cd, input int s, input int g);
    vec_t v;
    v.kind = kind; v.half = half; v.n = n;
    v.exp_bit = b; v.exp_cd = cd; v.exp_sym = s; v.exp_gl = g;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int s0, g0, cat, h, n;
    hist = '{1'b1, 1'b1, 1'b1};

    vecs.push_back(mk(KHold,    500, 0, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(KSeg,      25, 5, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mk(KSeg,      25, 3, 1'b1, 1'b1, 3, 0));
    vecs.push_back(mk(KSeg,      50, 1, 1'b1, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,      50, 1, 1'b1, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,      50, 1, 1'b0, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,      20, 1, 1'b0, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,       3, 1, 1'b0, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,      27, 1, 1'b0, 1'b1, 0, 1));
    vecs.push_back(mk(KSeg,      50, 2, 1'b0, 1'b1, 2, 0));
    vecs.push_back(mk(KSeg,      50, 2, 1'b0, 1'b1, 2, 0));
    vecs.push_back(mk(KTimeout,   0, 0, 1'b1, 1'b0, 1, 0));
    vecs.push_back(mk(KSeg,      30, 4, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(KSeg,      30, 1, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mk(KSeg,      50, 3, 1'b0, 1'b1, 3, 0));
    vecs.push_back(mk(KReset,     0, 0, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(KHold,     10, 0, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(KSeg,      25, 4, 1'b1, 1'b0, 0, 0));
    vecs.push_back(mk(KSeg,      25, 1, 1'b1, 1'b1, 0, 0));
    vecs.push_back(mk(KSeg,     200, 1, 1'b1, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,      25, 1, 1'b1, 1'b1, 1, 0));
    vecs.push_back(mk(KSeg,      25, 2, 1'b1, 1'b1, 2, 0));

    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("reset_state", {28'd0, bit_out, carrier_det, sym_strobe, glitch_err},
          {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      s0 = sym_cnt;
      g0 = gl_cnt;
      case (vecs[i].kind)
        KSeg:     run_seg(vecs[i].half, vecs[i].n);
        KHold:    for (int k = 0; k < vecs[i].half; k++) tick(lvl, 1'b1);
        KTimeout: do_timeout();
        default:  do_reset();
      endcase
      check($sformatf("vec%0d_bit_out", i), {31'd0, bit_out}, {31'd0, vecs[i].exp_bit});
      check($sformatf("vec%0d_carrier_det", i), {31'd0, carrier_det}, {31'd0, vecs[i].exp_cd});
      check($sformatf("vec%0d_sym_count", i), sym_cnt - s0, vecs[i].exp_sym);
      check($sformatf("vec%0d_glitch_count", i), gl_cnt - g0, vecs[i].exp_gl);
    end

    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        tick(1'($urandom_range(0, 1)), 1'b0);
        lvl = signal_in;
      end
      cat = int'($urandom_range(0, 9));
      if (cat == 0) h = int'($urandom_range(1, 7));
      else if (cat < 5) h = int'($urandom_range(15, 37));
      else if (cat < 9) h = int'($urandom_range(38, 80));
      else h = int'($urandom_range(190, 215));
      n = int'($urandom_range(1, 3));
      run_seg(h, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
